// File: rtl/arbitro_senoide_pkg.sv
// senoide_pkg: shared float32 type, state encoding and zero constant for the sine arbiter.
package senoide_pkg;
  localparam int FLOAT_W = 32;
  typedef logic [FLOAT_W-1:0] float32_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} arb_state_t;
  localparam float32_t FLOAT_CERO = 32'h0;
endpackage

// File: rtl/arbitro_senoide_if.sv
// arbitro_senoide_if: requester-side request/result bus of the sine arbiter.
interface arbitro_senoide_if import senoide_pkg::*; #(parameter int N = 4);
  logic [N-1:0] req_valid, req_ready, res_valid;
  logic [N*FLOAT_W-1:0] req_data;
  float32_t res_data;
  modport master(output req_valid, req_data, input req_ready, res_valid, res_data);
  modport slave(input req_valid, req_data, output req_ready, res_valid, res_data);
endinterface

// File: rtl/arbitro_senoide_rr.sv
// arbitro_rr: one-hot grant over req, round-robin from ptr, or lowest-index-wins with ARBITRO_SENOIDE_PRIORIDAD_FIJA_EN.
module arbitro_rr #(parameter int N = 4) (
  input  logic [N-1:0]         req,
`ifndef ARBITRO_SENOIDE_PRIORIDAD_FIJA_EN
  input  logic [$clog2(N)-1:0] ptr,
`endif
  output logic [N-1:0]         gnt
);
`ifdef ARBITRO_SENOIDE_PRIORIDAD_FIJA_EN
  assign gnt = req & (~req + 1'b1);
`else
  logic [N-1:0] hi;
  // requests at or above ptr win first; otherwise wrap to the lowest index
  assign hi  = req & ({N{1'b1}} << ptr);
  assign gnt = |hi ? hi & (~hi + 1'b1) : req & (~req + 1'b1);
`endif
endmodule

// File: rtl/arbitro_senoide.sv
// arbitro_senoide: shares one fixed-latency sine core among N requesters with tagged result return.
// Build option: ARBITRO_SENOIDE_PRIORIDAD_FIJA_EN selects fixed priority instead of round-robin.
module arbitro_senoide import senoide_pkg::*; #(
  parameter int N       = 4,
  parameter int LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  arbitro_senoide_if.slave               bus,
  output float32_t                       sin_in,
  input  float32_t                       sin_out,
  output logic                           idle,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);
  localparam int PW = $clog2(N);
  localparam int IW = $clog2(LATENCY+1);
  arb_state_t state;
  logic [N-1:0] gnt;
  logic [PW-1:0] gidx;
  logic ok, issue, retire;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0][PW-1:0] tag_o;
  assign ok = rst_n && en && state != S_DRAIN;
`ifdef ARBITRO_SENOIDE_PRIORIDAD_FIJA_EN
  arbitro_rr #(.N(N)) u_rr (.req(bus.req_valid & {N{ok}}), .gnt(gnt));
`else
  logic [PW-1:0] ptr;
  arbitro_rr #(.N(N)) u_rr (.req(bus.req_valid & {N{ok}}), .ptr(ptr), .gnt(gnt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (issue) ptr <= gidx == PW'(N-1) ? '0 : gidx + 1'b1;
`endif
  assign bus.req_ready = gnt;
  assign issue  = |gnt;
  assign retire = tag_v[LATENCY-1];
  always_comb begin
    gidx   = '0;
    sin_in = FLOAT_CERO;
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin
        gidx   = PW'(i);
        sin_in = bus.req_data[FLOAT_W*i +: FLOAT_W];
      end
  end
  // the last tag stage lines up with the core output of the same op
  assign bus.res_valid = retire ? N'(1) << tag_o[LATENCY-1] : '0;
  assign bus.res_data  = retire ? sin_out : FLOAT_CERO;
  assign idle = state == S_IDLE && inflight == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      inflight <= '0;
      tag_v    <= '0;
      tag_o    <= '0;
    end else begin
      inflight <= inflight + IW'(issue) - IW'(retire);
      tag_v    <= LATENCY'({tag_v, issue});
      tag_o    <= (LATENCY*PW)'({tag_o, gidx});
      state    <= state == S_IDLE ? (en && |bus.req_valid ? S_RUN : S_IDLE)
                : state == S_RUN  ? (!en ? S_DRAIN : (!(|bus.req_valid) && inflight == '0 ? S_IDLE : S_RUN))
                : (en ? S_RUN : (inflight == '0 ? S_IDLE : S_DRAIN));
    end
endmodule
